// File: rtl/scan_display.sv
// scan_display: four-digit multiplexed seven-segment scanner.
// F500K is edge-detected into single-cycle scan ticks. Each digit owns a slot of
// SCAN_DIV ticks, and the first BLANK_CYC ticks of every slot are blanked so
// that segments do not ghost onto the next digit. DATA/DP are latched once per
// frame, and a one-cycle FRAME pulse marks each frame wrap.
// Optional feature: define LZ_BLANK_EN to suppress leading zeros on digits 3..1.
module scan_display #(
  parameter int SCAN_DIV  = 125,
  parameter int BLANK_CYC = 2
) (
  input  logic        F10M,
  input  logic        RESET,
  input  logic        F500K,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  output logic [7:0]  SEG,
  output logic [3:0]  DIG,
  output logic        FRAME
);

  localparam logic [7:0] CNT_LAST = 8'(SCAN_DIV - 1);

  logic        fD;
  logic        tick;
  logic [7:0]  cnt;
  logic [1:0]  idx;
  logic [15:0] dataShadow;
  logic [3:0]  dpShadow;
  logic        wrapQ;
  logic        slotEnd;
  logic        blank;
  logic [3:0]  nibble;
  logic [6:0]  glyph;
  logic [7:0]  segNext;
  logic [3:0]  digNext;

  // Segment pattern for one hex digit, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick    = F500K & ~fD;
  assign slotEnd = (cnt == CNT_LAST);

  // Remember last F500K level so each rising edge yields exactly one tick.
  always_ff @(posedge F10M or negedge RESET) begin
    if (!RESET) fD <= 1'b0;
    else        fD <= F500K;
  end

  // Slot/digit counters advance on ticks; the frame wrap latches new display data.
  always_ff @(posedge F10M or negedge RESET) begin
    if (!RESET) begin
      cnt        <= 8'd0;
      idx        <= 2'd0;
      dataShadow <= 16'h0000;
      dpShadow   <= 4'h0;
      wrapQ      <= 1'b0;
    end else begin
      wrapQ <= 1'b0;
      if (tick) begin
        if (slotEnd) begin
          cnt <= 8'd0;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            dataShadow <= DATA;
            dpShadow   <= DP;
            wrapQ      <= 1'b1;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Head-of-slot blanking; with BLANK_CYC of zero the digit drives for the whole slot.
  generate
    if (BLANK_CYC > 0) begin : gBlank
      localparam logic [7:0] BLANK_LIM = 8'(BLANK_CYC);
      assign blank = (cnt < BLANK_LIM);
    end else begin : gNoBlank
      assign blank = 1'b0;
    end
  endgenerate

  // Pick the nibble of the digit currently being scanned.
  always_comb begin
    nibble = dataShadow[3:0];
    case (idx)
      2'd0:    nibble = dataShadow[3:0];
      2'd1:    nibble = dataShadow[7:4];
      2'd2:    nibble = dataShadow[11:8];
      default: nibble = dataShadow[15:12];
    endcase
  end

`ifdef LZ_BLANK_EN
  logic lz3;
  logic lz2;
  logic lz1;

  // A digit is a leading zero only if it and every digit above it are zero.
  assign lz3 = (dataShadow[15:12] == 4'h0);
  assign lz2 = lz3 & (dataShadow[11:8] == 4'h0);
  assign lz1 = lz2 & (dataShadow[7:4] == 4'h0);

  // Suppressed digits keep their enable and decimal point but light no segments.
  always_comb begin
    glyph = seg7(nibble);
    case (idx)
      2'd1:    if (lz1) glyph = 7'h00;
      2'd2:    if (lz2) glyph = 7'h00;
      2'd3:    if (lz3) glyph = 7'h00;
      default: glyph = seg7(nibble);
    endcase
  end
`else
  assign glyph = seg7(nibble);
`endif

  // Next-cycle digit enable and segments: blank, or drive the selected digit.
  always_comb begin
    segNext = 8'h00;
    digNext = 4'b1111;
    if (!blank) begin
      digNext = ~(4'b0001 << idx);
      segNext = {dpShadow[idx], glyph};
    end
  end

  // Outputs are registered so the pads see glitch-free digit switching.
  always_ff @(posedge F10M or negedge RESET) begin
    if (!RESET) begin
      SEG   <= 8'h00;
      DIG   <= 4'b1111;
      FRAME <= 1'b0;
    end else begin
      SEG   <= segNext;
      DIG   <= digNext;
      FRAME <= wrapQ;
    end
  end

endmodule
